// File: rtl/dkong3_obj_linebuf.sv
// dkong3_obj_linebuf: double-buffered sprite line buffer feeding the palette stage
// Ports:
//   I_CLK_6M    pixel clock, all state updates on the rising edge
//   W_1B2C_RST  asynchronous active-low reset
//   I_LINE_STB  line-start pulse, swaps write/display banks
//   I_WR_EN     sprite pixel write strobe
//   I_WR_X      write-bank pixel address
//   I_WR_D      sprite pixel {palette[3:0], colour[1:0]}
//   I_H         display horizontal counter
//   I_BLANKn    1 = active display (read and clear)
//   I_FLIP      1 = mirrored readout address
//   O_OBJ_D     registered object pixel
//   O_BANK      current display bank
module dkong3_obj_linebuf #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 6,
    parameter int FIRST_WINS = 1
) (
    input  logic              I_CLK_6M,
    input  logic              W_1B2C_RST,
    input  logic              I_LINE_STB,
    input  logic              I_WR_EN,
    input  logic [ADDR_W-1:0] I_WR_X,
    input  logic [DATA_W-1:0] I_WR_D,
    input  logic [ADDR_W-1:0] I_H,
    input  logic              I_BLANKn,
    input  logic              I_FLIP,
    output logic [DATA_W-1:0] O_OBJ_D,
    output logic              O_BANK
);
    // Both banks share one array; the top address bit is the bank index.
    logic [DATA_W-1:0] mem [2**(ADDR_W+1)];
    logic              sel;
    logic [ADDR_W-1:0] rd_x;
    logic [ADDR_W:0]   wa;
    logic [ADDR_W:0]   ra;
    logic [DATA_W-1:0] rd_d;
    logic              wr_ok;

    always_comb begin
        rd_x  = I_FLIP ? ~I_H : I_H;
        wa    = {~sel, I_WR_X};
        ra    = {sel, rd_x};
        rd_d  = mem[ra];
        // Transparent pixels never write; with FIRST_WINS an opaque pixel is kept.
        wr_ok = W_1B2C_RST && I_WR_EN && (I_WR_D[1:0] != 2'b00)
                && (FIRST_WINS == 0 || mem[wa][1:0] == 2'b00);
    end

    // RAM is not reset; write and clear always target different banks.
    always_ff @(posedge I_CLK_6M) begin
        if (wr_ok) mem[wa] <= I_WR_D;
        if (W_1B2C_RST && I_BLANKn) mem[ra] <= '0;
    end

    always_ff @(posedge I_CLK_6M or negedge W_1B2C_RST) begin
        if (!W_1B2C_RST) begin
            sel     <= 1'b0;
            O_OBJ_D <= '0;
        end else begin
            O_OBJ_D <= I_BLANKn ? rd_d : '0;
            if (I_LINE_STB) sel <= ~sel;
        end
    end

    assign O_BANK = sel;
endmodule

// File: tb/tb_dkong3_obj_linebuf.sv
// tb_dkong3_obj_linebuf: directed table plus randomized model check of both write-priority variants
module tb_dkong3_obj_linebuf;
    logic       clk = 1'b0;
    logic       rst;
    logic       stb, we, bl, fl;
    logic [7:0] x, h;
    logic [5:0] d;
    logic [5:0] out1, out0;
    logic       bank1, bank0;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    dkong3_obj_linebuf #(.ADDR_W(8), .DATA_W(6), .FIRST_WINS(1)) u_fw1 (
        .I_CLK_6M(clk), .W_1B2C_RST(rst), .I_LINE_STB(stb), .I_WR_EN(we),
        .I_WR_X(x), .I_WR_D(d), .I_H(h), .I_BLANKn(bl), .I_FLIP(fl),
        .O_OBJ_D(out1), .O_BANK(bank1)
    );
    dkong3_obj_linebuf #(.ADDR_W(8), .DATA_W(6), .FIRST_WINS(0)) u_fw0 (
        .I_CLK_6M(clk), .W_1B2C_RST(rst), .I_LINE_STB(stb), .I_WR_EN(we),
        .I_WR_X(x), .I_WR_D(d), .I_H(h), .I_BLANKn(bl), .I_FLIP(fl),
        .O_OBJ_D(out0), .O_BANK(bank0)
    );

    // Reference: [variant][bank][pixel]; variant 0 keeps the first opaque pixel, 1 the last.
    logic [5:0] mm [2][2][256];
    logic       msel;
    logic [5:0] mexp [2];

    task automatic model_tick();
        logic [7:0] rd;
        if (!rst) begin
            msel = 1'b0;
            mexp[0] = '0;
            mexp[1] = '0;
            return;
        end
        rd = fl ? 8'hFF - h : h;
        for (int f = 0; f < 2; f++) begin
            mexp[f] = bl ? mm[f][msel][rd] : 6'h00;
            if (bl) mm[f][msel][rd] = 6'h00;
            if (we && d[1:0] != 2'b00 && (f == 1 || mm[f][~msel][x][1:0] == 2'b00))
                mm[f][~msel][x] = d;
        end
        if (stb) msel = ~msel;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit co, input bit cb);
        model_tick();
        @(posedge clk);
        #1;
        if (co) begin
            chk("obj_fw1", out1, mexp[0]);
            chk("obj_fw0", out0, mexp[1]);
        end
        if (cb) begin
            chk("bank_fw1", bank1, msel);
            chk("bank_fw0", bank0, msel);
        end
    endtask

    task automatic sweep(input bit co);
        stb = 1'b1; we = 1'b0; bl = 1'b0; fl = 1'b0;
        step(co, 1'b1);
        stb = 1'b0; bl = 1'b1;
        for (int i = 0; i < 256; i++) begin
            h = 8'(i);
            step(co, 1'b0);
        end
        bl = 1'b0;
    endtask

    typedef struct {
        logic       stb, we;
        logic [7:0] x;
        logic [5:0] d;
        logic [7:0] h;
        logic       bl, fl;
        logic [5:0] e1, e0;
        logic       bk;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t mk(logic s, logic w, logic [7:0] xx, logic [5:0] dd, logic [7:0] hh,
                                logic b, logic f, logic [5:0] a1, logic [5:0] a0, logic k);
        vec_t v;
        v.stb = s; v.we = w; v.x = xx; v.d = dd; v.h = hh; v.bl = b; v.fl = f;
        v.e1 = a1; v.e0 = a0; v.bk = k;
        return v;
    endfunction

    initial begin
        for (int f = 0; f < 2; f++)
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 256; i++) mm[f][b][i] = 6'h00;
        msel = 1'b0; mexp[0] = '0; mexp[1] = '0;
        rst = 1'b0; stb = 1'b0; we = 1'b0; bl = 1'b0; fl = 1'b0;
        x = '0; d = '0; h = '0;
        #12;
        chk("rst_obj", out1, 0);
        chk("rst_bank", bank1, 0);
        @(negedge clk);
        rst = 1'b1;
        sweep(1'b0);
        sweep(1'b0);
        sweep(1'b1);
        sweep(1'b1);

        // stb, we, x, d, h, blank, flip, exp fw1, exp fw0, exp bank
        tv.push_back(mk(0, 1, 8'h40, 6'h2D, 8'h00, 0, 0, 6'h00, 6'h00, 0));
        tv.push_back(mk(0, 1, 8'h10, 6'h05, 8'h00, 0, 0, 6'h00, 6'h00, 0));
        tv.push_back(mk(0, 1, 8'h10, 6'h0A, 8'h00, 0, 0, 6'h00, 6'h00, 0));
        tv.push_back(mk(0, 1, 8'h10, 6'h08, 8'h00, 0, 0, 6'h00, 6'h00, 0));
        tv.push_back(mk(0, 1, 8'h03, 6'h11, 8'h00, 0, 0, 6'h00, 6'h00, 0));
        tv.push_back(mk(0, 1, 8'h30, 6'h1F, 8'h00, 0, 0, 6'h00, 6'h00, 0));
        tv.push_back(mk(1, 1, 8'h20, 6'h13, 8'h00, 0, 0, 6'h00, 6'h00, 1));
        tv.push_back(mk(0, 0, 8'h00, 6'h00, 8'h40, 1, 0, 6'h2D, 6'h2D, 1));
        tv.push_back(mk(0, 0, 8'h00, 6'h00, 8'h10, 1, 0, 6'h05, 6'h0A, 1));
        tv.push_back(mk(0, 0, 8'h00, 6'h00, 8'hFC, 1, 1, 6'h11, 6'h11, 1));
        tv.push_back(mk(0, 0, 8'h00, 6'h00, 8'h20, 1, 0, 6'h13, 6'h13, 1));
        tv.push_back(mk(0, 0, 8'h00, 6'h00, 8'h30, 0, 0, 6'h00, 6'h00, 1));
        tv.push_back(mk(0, 0, 8'h00, 6'h00, 8'h40, 1, 0, 6'h00, 6'h00, 1));
        tv.push_back(mk(0, 0, 8'h00, 6'h00, 8'h30, 1, 0, 6'h1F, 6'h1F, 1));
        tv.push_back(mk(0, 1, 8'h50, 6'h3E, 8'h30, 1, 0, 6'h00, 6'h00, 1));
        tv.push_back(mk(1, 0, 8'h00, 6'h00, 8'h50, 1, 0, 6'h00, 6'h00, 0));
        tv.push_back(mk(0, 0, 8'h00, 6'h00, 8'h50, 1, 0, 6'h3E, 6'h3E, 0));
        tv.push_back(mk(1, 0, 8'h00, 6'h00, 8'h00, 0, 0, 6'h00, 6'h00, 1));
        tv.push_back(mk(1, 0, 8'h00, 6'h00, 8'h00, 0, 0, 6'h00, 6'h00, 0));
        tv.push_back(mk(0, 0, 8'h00, 6'h00, 8'h50, 1, 0, 6'h00, 6'h00, 0));
        tv.push_back(mk(1, 0, 8'h00, 6'h00, 8'h40, 1, 0, 6'h00, 6'h00, 1));
        tv.push_back(mk(1, 0, 8'h00, 6'h00, 8'h00, 0, 0, 6'h00, 6'h00, 0));
        tv.push_back(mk(0, 0, 8'h00, 6'h00, 8'h40, 1, 0, 6'h00, 6'h00, 0));
        tv.push_back(mk(0, 1, 8'h60, 6'h27, 8'h00, 0, 0, 6'h00, 6'h00, 0));
        tv.push_back(mk(1, 0, 8'h00, 6'h00, 8'h00, 0, 0, 6'h00, 6'h00, 1));
        tv.push_back(mk(0, 0, 8'h00, 6'h00, 8'h60, 1, 0, 6'h27, 6'h27, 1));
        foreach (tv[i]) begin
            stb = tv[i].stb; we = tv[i].we; x = tv[i].x; d = tv[i].d;
            h = tv[i].h; bl = tv[i].bl; fl = tv[i].fl;
            step(1'b0, 1'b0);
            chk($sformatf("vec%0d_fw1", i), out1, tv[i].e1);
            chk($sformatf("vec%0d_fw0", i), out0, tv[i].e0);
            chk($sformatf("vec%0d_bank", i), bank1, tv[i].bk);
        end

        // Asynchronous reset mid-line while a pixel is on the output.
        stb = 1'b0; we = 1'b0; bl = 1'b0;
        #2;
        rst = 1'b0;
        msel = 1'b0; mexp[0] = '0; mexp[1] = '0;
        #1;
        chk("async_obj_fw1", out1, 0);
        chk("async_obj_fw0", out0, 0);
        chk("async_bank", bank1, 0);
        // A write strobe while in reset must be ignored.
        we = 1'b1; x = 8'h61; d = 6'h3F;
        step(1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        we = 1'b0;
        stb = 1'b1;
        step(1'b1, 1'b1);
        stb = 1'b0; bl = 1'b1; h = 8'h61;
        step(1'b0, 1'b0);
        chk("rst_nowrite_fw1", out1, 0);
        chk("rst_nowrite_fw0", out0, 0);
        sweep(1'b1);
        sweep(1'b1);

        for (int i = 0; i < 4000; i++) begin
            stb = ($urandom_range(0, 63) == 0);
            we  = $urandom_range(0, 1);
            x   = 8'($urandom_range(0, 255));
            d   = 6'($urandom_range(0, 63));
            h   = 8'($urandom_range(0, 255));
            bl  = ($urandom_range(0, 3) != 0);
            fl  = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) x = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) h = 8'($urandom_range(0, 7));
            step(1'b1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
